// File: rtl/noise_gen_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module   : noise_gen_pipelined_if
// Brief    : Start/stop handshake and sample bus of the Gaussian noise source.
// Revision : 1.0
// ============================================================================
interface noise_gen_pipelined_if #(
    parameter int OUT_W = 12
);
    logic [1:0]       SIGNAL_TYPE;
    logic [9:0]       T_IMPULSE;
    logic             SIGN_START_GEN;
    logic             OUT_REG_READY;
    logic             ABORT;
    logic             BUSY;
    logic             SIGN_START_CALC;
    logic             SIGN_STOP_CALC;
    logic             NOISE_VALID;
    logic [OUT_W-1:0] NOISE_OUT;

    modport master (
        output SIGNAL_TYPE, T_IMPULSE, SIGN_START_GEN, OUT_REG_READY, ABORT,
        input  BUSY, SIGN_START_CALC, SIGN_STOP_CALC, NOISE_VALID, NOISE_OUT
    );

    modport slave (
        input  SIGNAL_TYPE, T_IMPULSE, SIGN_START_GEN, OUT_REG_READY, ABORT,
        output BUSY, SIGN_START_CALC, SIGN_STOP_CALC, NOISE_VALID, NOISE_OUT
    );
endinterface
`default_nettype wire

// File: rtl/noise_gen_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : noise_gen_pipelined
// Brief    : LCG-based Gaussian noise source, N_SUM taps/sample, 3-stage
//            output pipeline. Define NOISE_GEN_SATURATE_EN to clip at S3.
// Revision : 1.0
// ============================================================================
module noise_gen_pipelined #(
    parameter int     OUT_W          = 12,
    parameter int     LCG_W          = 36,
    parameter int     TAP_W          = 16,
    parameter int     N_SUM          = 12,
    parameter longint LCG_A          = 31,
    parameter longint LCG_C          = 1,
    parameter longint SEED           = 16383,
    parameter int     SIGMA_MUL      = 682,
    parameter int     SHIFT          = 16,
    parameter int     MEAN           = 2047,
    parameter int     SAMPLES_PER_US = 13000,
    parameter int     NOISE_TYPE     = 3
) (
    input  wire                   CLK,
    input  wire                   RESET,
    noise_gen_pipelined_if.slave  bus
);
    localparam int SUM_W = TAP_W + 5;
    localparam int C_W   = SUM_W + 1;
    localparam int P_W   = C_W + 17;

    localparam logic [LCG_W-1:0]      C_LCG_A  = LCG_W'(LCG_A);
    localparam logic [LCG_W-1:0]      C_LCG_C  = LCG_W'(LCG_C);
    localparam logic [LCG_W-1:0]      C_SEED   = LCG_W'(SEED);
    localparam logic signed [C_W-1:0] C_OFFSET = C_W'(N_SUM) << (TAP_W - 1);
    localparam logic signed [P_W-1:0] C_SIGMA  = P_W'(SIGMA_MUL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state, w_next_state;
    logic [31:0]           r_num, r_cnt;
    logic [LCG_W-1:0]      r_z, w_z_step;
    logic [SUM_W-1:0]      w_sum, r_sum;
    logic signed [C_W-1:0] w_c;
    logic signed [P_W-1:0] w_prod, w_p, r_p;
    logic [OUT_W-1:0]      w_noise, r_out;
    logic                  r_v1, r_v2, r_v3;
    logic                  r_start_pulse, r_abort_stop;
    logic                  w_accept, w_issue, w_last_issue, w_drain_done, w_abort;

    assign w_accept = (r_state == S_IDLE) && bus.SIGN_START_GEN && bus.OUT_REG_READY
                      && (bus.SIGNAL_TYPE == 2'(NOISE_TYPE)) && (bus.T_IMPULSE != '0);
    assign w_issue      = (r_state == S_RUN) && !bus.ABORT;
    assign w_last_issue = w_issue && ((r_cnt + 32'd1) == r_num);
    // The last sample sits in S3 once S1 and S2 are empty.
    assign w_drain_done = (r_state == S_DRAIN) && !r_v1 && !r_v2;
    assign w_abort      = bus.ABORT && ((r_state == S_RUN)
                          || ((r_state == S_DRAIN) && !w_drain_done));

    // N_SUM chained LCG steps per clock; state carries across samples.
    always_comb begin
        w_z_step = r_z;
        w_sum    = '0;
        for (int i = 0; i < N_SUM; i++) begin
            w_z_step = C_LCG_A * w_z_step + C_LCG_C;
            w_sum    = w_sum + SUM_W'(w_z_step[LCG_W-1 -: TAP_W]);
        end
    end

    assign w_c    = $signed({1'b0, r_sum}) - C_OFFSET;
    assign w_prod = $signed({{(P_W-C_W){w_c[C_W-1]}}, w_c}) * C_SIGMA;
    assign w_p    = w_prod >>> SHIFT;

`ifdef NOISE_GEN_SATURATE_EN
    localparam logic signed [P_W:0] C_MEAN = (P_W+1)'(MEAN);
    localparam logic signed [P_W:0] C_YMAX = (P_W+1)'((1 << OUT_W) - 1);
    logic signed [P_W:0] w_y;
    assign w_y = $signed({r_p[P_W-1], r_p}) + C_MEAN;
    always_comb begin
        if (w_y[P_W])
            w_noise = '0;
        else if (w_y > C_YMAX)
            w_noise = '1;
        else
            w_noise = w_y[OUT_W-1:0];
    end
`else
    localparam logic signed [P_W-1:0] C_MEAN_P = P_W'(MEAN);
    assign w_noise = OUT_W'(r_p + C_MEAN_P);
`endif

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_RUN;
            S_RUN: begin
                if (w_abort)
                    w_next_state = S_IDLE;
                else if (w_last_issue)
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: if (w_abort || w_drain_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY            = (r_state != S_IDLE);
        bus.SIGN_START_CALC = r_start_pulse;
        bus.SIGN_STOP_CALC  = w_drain_done || r_abort_stop;
        bus.NOISE_VALID     = r_v3;
        bus.NOISE_OUT       = r_out;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_num         <= '0;
            r_cnt         <= '0;
            r_z           <= C_SEED;
            r_sum         <= '0;
            r_p           <= '0;
            r_out         <= '0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_v3          <= 1'b0;
            r_start_pulse <= 1'b0;
            r_abort_stop  <= 1'b0;
        end else begin
            r_start_pulse <= w_accept;
            r_abort_stop  <= w_abort;
            if (w_accept) begin
                r_num <= 32'(bus.T_IMPULSE) * 32'(SAMPLES_PER_US);
                r_cnt <= '0;
                r_z   <= C_SEED;
            end else if (w_issue) begin
                r_z   <= w_z_step;
                r_cnt <= r_cnt + 32'd1;
            end
            r_v1 <= w_issue;
            r_v2 <= r_v1 && !w_abort;
            r_v3 <= r_v2 && !w_abort;
            if (w_issue)
                r_sum <= w_sum;
            if (r_v1)
                r_p <= w_p;
            if (r_v2 && !w_abort)
                r_out <= w_noise;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_noise_gen_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_noise_gen_pipelined
// Brief    : Directed + randomized bench for three noise_gen_pipelined configs.
// Revision : 1.0
// ============================================================================
module tb_noise_gen_pipelined;
`ifdef NOISE_GEN_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] stype = 2'd0;
    logic [9:0] tim = 10'd0;
    logic       start = 1'b0, ready = 1'b0, abort = 1'b0;
    int         n_tests = 0, n_fail = 0;
    int         qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    noise_gen_pipelined_if #(.OUT_W(12)) if_a ();
    noise_gen_pipelined_if #(.OUT_W(12)) if_b ();
    noise_gen_pipelined_if #(.OUT_W(12)) if_c ();

    assign if_a.SIGNAL_TYPE = stype;  assign if_b.SIGNAL_TYPE = stype;  assign if_c.SIGNAL_TYPE = stype;
    assign if_a.T_IMPULSE = tim;      assign if_b.T_IMPULSE = tim;      assign if_c.T_IMPULSE = tim;
    assign if_a.SIGN_START_GEN = start; assign if_b.SIGN_START_GEN = start; assign if_c.SIGN_START_GEN = start;
    assign if_a.OUT_REG_READY = ready; assign if_b.OUT_REG_READY = ready; assign if_c.OUT_REG_READY = ready;
    assign if_a.ABORT = abort;        assign if_b.ABORT = abort;        assign if_c.ABORT = abort;

    noise_gen_pipelined #(.SAMPLES_PER_US(13)) u_a (.CLK(clk), .RESET(rst), .bus(if_a));
    noise_gen_pipelined #(.SAMPLES_PER_US(13), .MEAN(4000), .SIGMA_MUL(4096)) u_b (.CLK(clk), .RESET(rst), .bus(if_b));
    noise_gen_pipelined #(.SAMPLES_PER_US(13), .SIGMA_MUL(0)) u_c (.CLK(clk), .RESET(rst), .bus(if_c));

    always @(negedge clk) begin
        if (if_a.NOISE_VALID) qa.push_back(int'(if_a.NOISE_OUT));
        if (if_b.NOISE_VALID) qb.push_back(int'(if_b.NOISE_OUT));
        if (if_c.NOISE_VALID) qc.push_back(int'(if_c.NOISE_OUT));
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum 12 LCG taps, centre, scale, offset, then clip or wrap to 12 bits.
    function automatic int model_sample(inout longint unsigned z, input int mean, input int sigma);
        longint s = 0;
        longint c, y;
        for (int j = 0; j < 12; j++) begin
            z = (z * 31 + 1) & 64'hF_FFFF_FFFF;
            s += longint'(z >> 20);
        end
        c = s - 12 * 32768;
        y = ((c * sigma) >>> 16) + mean;
        if (SAT) begin
            if (y < 0) y = 0;
            else if (y > 4095) y = 4095;
        end else begin
            y = y & 4095;
        end
        return int'(y);
    endfunction

    task automatic cmp_q(input string tag, input int q[$], input int n, input int mean, input int sigma);
        longint unsigned z = 16383;
        int e;
        chk({tag, "_count"}, q.size(), n);
        if (q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                e = model_sample(z, mean, sigma);
                chk($sformatf("%s[%0d]", tag, i), q[i], e);
                if (q[i] != e) break;
            end
        end
    endtask

    task automatic check_all(input string tag, input int n);
        cmp_q({tag, "_a"}, qa, n, 2047, 682);
        cmp_q({tag, "_b"}, qb, n, 4000, 4096);
        cmp_q({tag, "_c"}, qc, n, 2047, 0);
        qa.delete(); qb.delete(); qc.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int cnt = 0;
        do begin
            next_cycle();
            @(negedge clk);
            cnt++;
        end while ((if_a.BUSY || if_b.BUSY || if_c.BUSY) && cnt < budget);
        chk("idle_timeout", longint'(if_a.BUSY | if_b.BUSY | if_c.BUSY), 0);
        next_cycle();
    endtask

    task automatic run_pulse(input int t);
        next_cycle();
        start = 1'b1; tim = 10'(t); stype = 2'd3; ready = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_idle(t * 13 + 20);
    endtask

    // 13-sample pulse, cycle-accurate; ab>0 raises ABORT in cycle ab and restarts in ab+1.
    task automatic timed_pulse(input int ab);
        int last;
        last = (ab == 0) ? 16 : ab;
        next_cycle();
        start = 1'b1; tim = 10'd1; stype = 2'd3; ready = 1'b1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            next_cycle();
            start = (ab != 0) && (cyc == ab + 1);
            abort = (cyc == ab);
            @(negedge clk);
            chk($sformatf("valid_c%0d", cyc), longint'(if_a.NOISE_VALID), longint'(cyc >= 4 && cyc <= last));
            chk($sformatf("busy_c%0d", cyc), longint'(if_a.BUSY), longint'((ab == 0) ? (cyc <= 16) : (cyc <= ab)));
            chk($sformatf("start_c%0d", cyc), longint'(if_a.SIGN_START_CALC), longint'(cyc == 1));
            chk($sformatf("stop_c%0d", cyc), longint'(if_a.SIGN_STOP_CALC), longint'((ab == 0) ? (cyc == 16) : (cyc == ab + 1)));
            if (ab != 0 && cyc == ab + 1) break;
        end
        if (ab != 0) begin
            next_cycle();
            start = 1'b0;
            @(negedge clk);
            chk("restart_start", longint'(if_a.SIGN_START_CALC), 1);
            chk("restart_busy", longint'(if_a.BUSY), 1);
            check_all("abort_part", (ab > 3) ? ab - 3 : 0);
            wait_idle(40);
            check_all("abort_restart", 13);
        end else begin
            next_cycle();
            check_all("basic", 13);
        end
    endtask

    task automatic gate(input logic [1:0] st, input logic rd, input logic [9:0] t);
        logic act = 1'b0;
        next_cycle();
        stype = st; ready = rd; tim = t; start = 1'b1;
        repeat (20) begin
            next_cycle();
            @(negedge clk);
            act |= if_a.BUSY | if_a.SIGN_START_CALC | if_a.SIGN_STOP_CALC | if_a.NOISE_VALID;
        end
        start = 1'b0;
        next_cycle();
        chk("gate_activity", longint'(act), 0);
        chk("gate_samples", qa.size() + qb.size() + qc.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, acc, ab, clips;
        real m, v;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_busy", longint'(if_a.BUSY), 0);
        chk("rst_start", longint'(if_a.SIGN_START_CALC), 0);
        chk("rst_stop", longint'(if_a.SIGN_STOP_CALC), 0);
        chk("rst_valid", longint'(if_a.NOISE_VALID), 0);
        chk("rst_out", longint'(if_a.NOISE_OUT), 0);
        chk("rst_out_b", longint'(if_b.NOISE_OUT), 0);
        next_cycle();
        rst = 1'b0;

        timed_pulse(0);
        timed_pulse(0);

        gate(2'd2, 1'b1, 10'd1);
        gate(2'd3, 1'b0, 10'd1);
        gate(2'd3, 1'b1, 10'd0);

        timed_pulse(8);
        repeat (3) begin
            ab = $urandom_range(1, 15);
            timed_pulse(ab);
        end

        // Reset mid-pulse in cycle 8.
        next_cycle();
        start = 1'b1; tim = 10'd1; stype = 2'd3; ready = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            next_cycle();
            start = 1'b0;
            rst = (cyc == 8);
        end
        @(negedge clk);
        chk("mid_rst_busy", longint'(if_a.BUSY), 0);
        chk("mid_rst_valid", longint'(if_a.NOISE_VALID), 0);
        chk("mid_rst_out", longint'(if_a.NOISE_OUT), 0);
        chk("mid_rst_stop", longint'(if_a.SIGN_STOP_CALC), 0);
        chk("mid_rst_start", longint'(if_a.SIGN_START_CALC), 0);
        next_cycle();
        @(negedge clk);
        chk("mid_rst_stop_late", longint'(if_a.SIGN_STOP_CALC), 0);
        check_all("rst_part", 5);

        // Reset and start in the same cycle.
        next_cycle();
        rst = 1'b1; start = 1'b1;
        next_cycle();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", longint'(if_a.BUSY), 0);
        chk("rst_start_calc", longint'(if_a.SIGN_START_CALC), 0);
        next_cycle();
        @(negedge clk);
        chk("rst_start_busy2", longint'(if_a.BUSY), 0);

        // Randomized gating and pulse lengths.
        repeat (6) begin
            t = $urandom_range(0, 3);
            next_cycle();
            stype = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
            ready = ($urandom_range(0, 3) != 0);
            tim = 10'(t);
            acc = (t != 0 && ready && stype == 2'd3) ? t * 13 : 0;
            start = 1'b1;
            next_cycle();
            start = 1'b0;
            wait_idle(t * 13 + 20);
            next_cycle();
            check_all("rand", acc);
        end

        // Large-scale pulse exercising clipping/wrap.
        run_pulse(77);
`ifdef NOISE_GEN_SATURATE_EN
        clips = 0;
        foreach (qb[i]) if (qb[i] == 0 || qb[i] == 4095) clips++;
        chk("clip_seen", longint'(clips > 0), 1);
`endif
        check_all("sat", 1001);

        // Distribution check on 6500 default samples.
        run_pulse(500);
        m = 0.0; v = 0.0;
        foreach (qa[i]) m += real'(qa[i]);
        m = m / real'(qa.size() > 0 ? qa.size() : 1);
        foreach (qa[i]) v += (real'(qa[i]) - m) * (real'(qa[i]) - m);
        v = $sqrt(v / real'(qa.size() > 0 ? qa.size() : 1));
        chk("stat_mean", longint'(m > 1987.0 && m < 2107.0), 1);
        chk("stat_sigma", longint'(v > 602.0 && v < 762.0), 1);
        check_all("stat", 6500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
